// File: rtl/pos_cell_pkg.sv
// Shared types and constants for the cell position RAM sequencer.
// State encoding, read latency and count-word field width.
package pos_cell_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_RD,
    CNT_WAIT,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  localparam int RD_LATENCY = 2;
  localparam int CNT_W      = 16;

  function automatic logic [CNT_W-1:0] clamp_cnt(
    input logic [CNT_W-1:0] raw,
    input logic [CNT_W-1:0] max_c
  );
    return (raw > max_c) ? max_c : raw;
  endfunction

endpackage

// File: rtl/pos_cell_fifo.sv
// Small synchronous FIFO holding {pid, position} for the read stream.
// Push and pop in the same cycle leave the occupancy unchanged.
module pos_cell_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [WIDTH-1:0] din,
  input  logic          pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]   count,
  output logic          empty
);

  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((cnt != C_FULL) || do_pop);
  assign dout    = mem[rp];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + P_ONE;
      end
      if (do_pop) begin
        rp <= rp + P_ONE;
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + C_ONE;
      end else if (!do_push && do_pop) begin
        cnt <= cnt - C_ONE;
      end
    end
  end

endmodule

// File: rtl/pos_cell_ctrl.sv
// Sequencer/arbiter sharing one cell position RAM between the
// force-eval read streamer and the motion-update writer.
module pos_cell_ctrl
  import pos_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_pid,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int FW = DATA_WIDTH + ADDR_WIDTH;
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int CW = FA + 1;
  localparam int OW = CW + 1;
  localparam int LS = RD_LATENCY - 1;

  localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] SPEC_MAX = ADDR_WIDTH'(RD_LATENCY);
  localparam logic [OW-1:0]         CREDIT   = OW'(FIFO_DEPTH);
  localparam logic [CW-1:0]         F_ONE    = CW'(1);

  state_e                  state_q;
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   count_q;
  logic [ADDR_WIDTH-1:0]   next_pid_q;
  logic                    wr_ready_q;

  logic [LS:0]             p_v;
  logic [LS:0]             p_cnt;
  logic [ADDR_WIDTH-1:0]   p_pid [RD_LATENCY];

  logic                    wr_take;
  logic                    cnt_issue;
  logic                    spec_issue;
  logic                    str_issue;
  logic                    cnt_arrive;
  logic [ADDR_WIDTH-1:0]   cnt_new;
  logic [OW-1:0]           occ;
  logic                    credit_ok;
  logic                    drain_done;

  logic                    f_push;
  logic                    f_pop;
  logic [FW-1:0]           f_dout;
  logic [CW-1:0]           f_cnt;
  logic                    f_empty;

  assign wr_take   = wr_valid && wr_ready_q;
  assign occ       = {1'b0, f_cnt} + OW'(p_v[0]) + OW'(p_v[LS]);
  assign credit_ok = (occ < CREDIT);

  assign cnt_arrive = p_v[LS] && p_cnt[LS];
  assign cnt_new    = ADDR_WIDTH'(clamp_cnt(mem_q[CNT_W-1:0], MAX_CNT));

  // Entries past the latched count are early speculative reads; drop them.
  assign f_push = p_v[LS] && !p_cnt[LS] && (p_pid[LS] <= count_q);
  assign f_pop  = rd_valid && rd_ready;

  assign drain_done = (p_v == '0) &&
                      ((f_cnt == '0) || ((f_cnt == F_ONE) && f_pop));

  pos_cell_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH),
    .AW    (FA)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .din   ({p_pid[LS], mem_q}),
    .pop   (f_pop),
    .dout  (f_dout),
    .count (f_cnt),
    .empty (f_empty)
  );

  assign rd_valid = !f_empty;
  assign rd_pid   = f_dout[FW-1:DATA_WIDTH];
  assign rd_data  = f_dout[DATA_WIDTH-1:0];
  assign rd_busy  = (state_q != IDLE);
  assign rd_done  = (state_q == DONE);
  assign wr_ready = wr_ready_q;
  assign mem_wren = wr_take;
  assign mem_rden = cnt_issue || spec_issue || str_issue;
  assign mem_data = wr_take ? wr_data : '0;

  // Particles 1..2 are read while the count word is still in flight.
  always_comb begin
    state_d    = state_q;
    cnt_issue  = 1'b0;
    spec_issue = 1'b0;
    str_issue  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_start) state_d = CNT_RD;
      end
      CNT_RD: begin
        cnt_issue = !wr_take;
        if (!wr_take) state_d = CNT_WAIT;
      end
      CNT_WAIT: begin
        spec_issue = !wr_take && credit_ok &&
                     (next_pid_q <= SPEC_MAX);
        if (cnt_arrive) begin
          state_d = (cnt_new == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        str_issue = !wr_take && credit_ok &&
                    (next_pid_q <= count_q);
        if ((next_pid_q > count_q) ||
            (str_issue && (next_pid_q == count_q))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_address = '0;
    unique case (1'b1)
      wr_take:    mem_address = wr_addr;
      cnt_issue:  mem_address = '0;
      spec_issue: mem_address = next_pid_q;
      str_issue:  mem_address = next_pid_q;
      default:    mem_address = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      next_pid_q <= A_ONE;
      wr_ready_q <= 1'b0;
      p_v        <= '0;
      p_cnt      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        p_pid[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ready_q <= 1'b1;
      if (state_q == IDLE) begin
        next_pid_q <= A_ONE;
      end else if (spec_issue || str_issue) begin
        next_pid_q <= next_pid_q + A_ONE;
      end
      if ((state_q == CNT_WAIT) && cnt_arrive) begin
        count_q <= cnt_new;
      end
      p_v      <= {p_v[LS-1:0], mem_rden};
      p_cnt    <= {p_cnt[LS-1:0], cnt_issue};
      p_pid[0] <= next_pid_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        p_pid[i] <= p_pid[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pos_cell_ctrl.sv
// Directed bench for pos_cell_ctrl with a 2-cycle RAM model and a
// scoreboard of expected {pid, data} popped on each handshake.
module tb_pos_cell_ctrl;

  localparam int DW = 96;
  localparam int AW = 8;

  typedef struct packed {
    logic [AW-1:0] pid;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_start;
  logic          rd_busy;
  logic          rd_done;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_pid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  logic [DW-1:0] ram [256];
  logic [DW-1:0] r1;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int s_cyc, first_v, last_v, done_cyc, busy_fall;
  int done_cnt = 0, delivered = 0, wren_cnt = 0;
  int port_bad = 0, credit_bad = 0;
  int occ = 0, h1 = 0, h2 = 0, a1 = 0, a2 = 0;
  int cur_count = 0;
  logic prev_busy = 1'b0;

  always #5 clk = ~clk;

  pos_cell_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_start    (rd_start),
    .rd_busy     (rd_busy),
    .rd_done     (rd_done),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_pid      (rd_pid),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_wren) ram[mem_address] <= mem_data;
    r1    <= mem_rden ? ram[mem_address] : r1;
    mem_q <= r1;
  end

  function automatic logic [DW-1:0] pat(input int i, input int salt);
    return {32'(i * 3 + salt), 32'h5A00_0000 + 32'(i), 32'(i) ^ 32'(salt << 8)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    occ = 0; h1 = 0; h2 = 0; a1 = 0; a2 = 0;
    prev_busy = 1'b0;
  endtask

  // One clock: observe at negedge, then return 1ns after posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (rd_done) begin done_cnt++; done_cyc = cyc; end
      if (prev_busy && !rd_busy) busy_fall = cyc;
      prev_busy = rd_busy;
      if (mem_wren) wren_cnt++;
      if (mem_wren && mem_rden) port_bad++;
      if (mem_rden && mem_address != 0 && (occ + h1 + h2 >= 4)) credit_bad++;
      if (rd_valid && first_v < 0) first_v = cyc;
      occ = occ + ((h2 != 0 && a2 <= cur_count) ? 1 : 0)
                - ((rd_valid && rd_ready) ? 1 : 0);
      h2 = h1; a2 = a1;
      h1 = (mem_rden && mem_address != 0) ? 1 : 0;
      a1 = int'(mem_address);
      if (rd_valid && rd_ready) begin
        chk("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pid", 128'(rd_pid), 128'(e.pid));
          chk("data", 128'(rd_data), 128'(e.data));
        end
        last_v = cyc;
        delivered++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input int n, input int raw, input int salt);
    for (int i = 0; i <= n; i++) begin
      ld_en = 1'b1;
      ld_addr = AW'(i);
      ld_data = (i == 0) ? DW'(raw) : pat(i, salt);
      step();
    end
    ld_en = 1'b0;
  endtask

  task automatic expect_stream(input int n, input int salt);
    for (int i = 1; i <= n; i++) exp_q.push_back({AW'(i), pat(i, salt)});
  endtask

  task automatic start();
    first_v = -1;
    rd_start = 1'b1;
    s_cyc = cyc;
    step();
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit tog);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > d0) break;
      if (tog) rd_ready = ~rd_ready;
      step();
    end
    chk(tag, 128'(done_cnt > d0), 128'(1));
  endtask

  initial begin
    int base;
    int wc0;
    int d_before;
    rst_n = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    first_v = -1; last_v = 0; done_cyc = 0; busy_fall = 0;

    #12;
    chk("rst_outs", 128'(|{rd_busy, rd_done, rd_valid, rd_data, rd_pid, wr_ready,
                          mem_address, mem_data, mem_rden, mem_wren}), 128'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("wr_ready_up", 128'(wr_ready), 128'(1));
    chk("idle_busy", 128'(rd_busy), 128'(0));

    // count=3, always ready
    load(3, 3, 11);
    cur_count = 3;
    expect_stream(3, 11);
    rd_ready = 1'b1;
    base = delivered;
    start();
    wait_done("t1_done", 40, 1'b0);
    chk("t1_first_lat", 128'(first_v - s_cyc), 128'(5));
    chk("t1_done_after_last", 128'(done_cyc), 128'(last_v + 1));
    chk("t1_count", 128'(delivered - base), 128'(3));
    chk("t1_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("t1_busy_low", 128'(rd_busy), 128'(0));

    // count=0
    load(0, 0, 0);
    cur_count = 0;
    base = delivered;
    start();
    wait_done("t2_done", 20, 1'b0);
    step();
    chk("t2_done_lat", 128'(done_cyc - s_cyc), 128'(4));
    chk("t2_no_valid", 128'(first_v), 128'(-1));
    chk("t2_busy_fall", 128'(busy_fall), 128'(done_cyc + 1));
    chk("t2_count", 128'(delivered - base), 128'(0));

    // count=10, rd_ready toggling
    load(10, 10, 23);
    cur_count = 10;
    expect_stream(10, 23);
    rd_ready = 1'b1;
    base = delivered;
    start();
    wait_done("t3_done", 80, 1'b1);
    rd_ready = 1'b1;
    chk("t3_count", 128'(delivered - base), 128'(10));
    chk("t3_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("t3_credit", 128'(credit_bad), 128'(0));

    // writes held 3 cycles mid-stream
    load(10, 10, 37);
    cur_count = 10;
    expect_stream(10, 37);
    base = delivered;
    start();
    repeat (6) step();
    wc0 = wren_cnt;
    wr_valid = 1'b1; wr_addr = 8'h80; wr_data = 96'hFEED_0000_CAFE_0000_BEEF_0042;
    chk("t4_wr_ready", 128'(wr_ready), 128'(1));
    repeat (3) step();
    wr_valid = 1'b0;
    wait_done("t4_done", 60, 1'b0);
    chk("t4_wren_cycles", 128'(wren_cnt - wc0), 128'(3));
    chk("t4_ram_written", 128'(ram[8'h80]), 128'(96'hFEED_0000_CAFE_0000_BEEF_0042));
    chk("t4_count", 128'(delivered - base), 128'(10));
    chk("t4_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("t4_port_excl", 128'(port_bad), 128'(0));

    // count word 300 clamps to 219
    load(219, 300, 51);
    cur_count = 219;
    expect_stream(219, 51);
    base = delivered;
    start();
    wait_done("t5_done", 600, 1'b0);
    chk("t5_count", 128'(delivered - base), 128'(219));
    chk("t5_sb_empty", 128'(exp_q.size()), 128'(0));

    // reset during STREAM after 4 delivered
    load(8, 8, 67);
    cur_count = 8;
    expect_stream(8, 67);
    base = delivered;
    d_before = done_cnt;
    start();
    for (int i = 0; i < 40; i++) begin
      if (delivered - base >= 4) break;
      step();
    end
    chk("t6_got4", 128'(delivered - base), 128'(4));
    rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", 128'(|{rd_busy, rd_done, rd_valid, rd_data, rd_pid, wr_ready,
                             mem_address, mem_data, mem_rden, mem_wren}), 128'(0));
    exp_q.delete();
    mon_clear();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b1;
    chk("t6_no_done", 128'(done_cnt), 128'(d_before));
    expect_stream(8, 67);
    base = delivered;
    start();
    wait_done("t6_done", 60, 1'b0);
    chk("t6_first_lat", 128'(first_v - s_cyc), 128'(5));
    chk("t6_count", 128'(delivered - base), 128'(8));
    chk("t6_sb_empty", 128'(exp_q.size()), 128'(0));
    chk("credit_total", 128'(credit_bad), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
